// File: rtl/jzjpcc_mmio_ports.sv
// Memory-mapped 32-bit output/input port block with synchronised inputs and per-port change flags.
// Define JZJPCC_MMIO_IRQ_EN to add the irq mask register (word 2N+1) and the change interrupt.
module jzjpcc_mmio_ports #(
    parameter int unsigned NUM_PORTS   = 2,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic                    clock,
    input  logic                    not_reset,
    input  logic [4:0]              address,
    input  logic [31:0]             writeData,
    input  logic [3:0]              byteWriteMask,
    input  logic                    writeEnable,
    input  logic                    readEnable,
    output logic [31:0]             readData,
    output logic [32*NUM_PORTS-1:0] portOut,
    input  logic [32*NUM_PORTS-1:0] portIn,
    output logic                    irq
);
    localparam int unsigned PW        = 32 * NUM_PORTS;
    localparam logic [4:0]  FLAG_ADDR = 5'(2 * NUM_PORTS);
`ifdef JZJPCC_MMIO_IRQ_EN
    localparam logic [4:0]  MASK_ADDR = 5'(2 * NUM_PORTS + 1);
`endif

    logic [PW-1:0]        port_out_q, port_out_d;
    logic [PW-1:0]        sync1_q, sync1_d;
    logic [PW-1:0]        sync2_q, sync2_d;
    logic [PW-1:0]        prev_q, prev_d;
    logic [NUM_PORTS-1:0] flag_q, flag_d;
    logic [NUM_PORTS-1:0] flag_set, flag_clr;
    logic [31:0]          read_data_q, read_data_d;
    logic [31:0]          rd_word;
`ifdef JZJPCC_MMIO_IRQ_EN
    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic                 irq_q, irq_d;
`endif

    // Register map decode, byte-masked writes, change detection and read capture.
    always_comb begin
        port_out_d  = port_out_q;
        read_data_d = read_data_q;
        sync1_d     = portIn;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        flag_set    = '0;
        flag_clr    = '0;
        rd_word     = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (address == 5'(i)) begin
                rd_word = port_out_q[32*i +: 32];
                if (writeEnable) begin
                    for (int b = 0; b < 4; b++) begin
                        if (byteWriteMask[b]) begin
                            port_out_d[32*i + 8*b +: 8] = writeData[8*b +: 8];
                        end
                    end
                end
            end
            if (address == 5'(NUM_PORTS + i)) begin
                rd_word = sync2_q[32*i +: 32];
            end
            flag_set[i] = (sync2_q[32*i +: 32] != prev_q[32*i +: 32]);
        end
        if (address == FLAG_ADDR) begin
            rd_word = 32'(flag_q);
            if (writeEnable && byteWriteMask[0]) begin
                flag_clr = writeData[NUM_PORTS-1:0];
            end
        end
        // A fresh change beats a same-cycle clear so no event is lost.
        flag_d = (flag_q & ~flag_clr) | flag_set;
`ifdef JZJPCC_MMIO_IRQ_EN
        mask_d = mask_q;
        if (address == MASK_ADDR) begin
            rd_word = 32'(mask_q);
            if (writeEnable && byteWriteMask[0]) begin
                mask_d = writeData[NUM_PORTS-1:0];
            end
        end
        irq_d = |(flag_q & mask_q);
`endif
        if (readEnable) begin
            read_data_d = rd_word;
        end
    end

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            port_out_q  <= {NUM_PORTS{RESET_VALUE}};
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            flag_q      <= '0;
            read_data_q <= '0;
        end else begin
            port_out_q  <= port_out_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            flag_q      <= flag_d;
            read_data_q <= read_data_d;
        end
    end

`ifdef JZJPCC_MMIO_IRQ_EN
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    assign readData = read_data_q;
    assign portOut  = port_out_q;

endmodule

// File: tb/tb_jzjpcc_mmio_ports.sv
// Directed self-checking bench for jzjpcc_mmio_ports (NUM_PORTS=2, default reset value).
module tb_jzjpcc_mmio_ports;
    localparam int unsigned NP = 2;
`ifdef JZJPCC_MMIO_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             not_reset;
    logic [4:0]       address;
    logic [31:0]      writeData;
    logic [3:0]       byteWriteMask;
    logic             writeEnable;
    logic             readEnable;
    logic [31:0]      readData;
    logic [32*NP-1:0] portOut;
    logic [32*NP-1:0] portIn;
    logic             irq;

    int checks   = 0;
    int failures = 0;

    jzjpcc_mmio_ports #(
        .NUM_PORTS  (NP),
        .RESET_VALUE(32'h0000_0000)
    ) dut (
        .clock        (clock),
        .not_reset    (not_reset),
        .address      (address),
        .writeData    (writeData),
        .byteWriteMask(byteWriteMask),
        .writeEnable  (writeEnable),
        .readEnable   (readEnable),
        .readData     (readData),
        .portOut      (portOut),
        .portIn       (portIn),
        .irq          (irq)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic access(input bit we, input bit re, input logic [4:0] a,
                          input logic [31:0] d, input logic [3:0] m);
        writeEnable   = we;
        readEnable    = re;
        address       = a;
        writeData     = d;
        byteWriteMask = m;
        tick();
        writeEnable = 1'b0;
        readEnable  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
        access(1'b1, 1'b0, a, d, m);
    endtask

    task automatic rd(input logic [4:0] a);
        access(1'b0, 1'b1, a, 32'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        not_reset     = 1'b0;
        address       = '0;
        writeData     = '0;
        byteWriteMask = '0;
        writeEnable   = 1'b0;
        readEnable    = 1'b0;
        portIn        = '0;
        repeat (2) tick();
        check_eq("reset_portout", 64'(portOut), 64'h0);
        check_eq("reset_readdata", 64'(readData), 64'h0);
        check_eq("reset_irq", 64'(irq), 64'h0);
        not_reset = 1'b1;

        // Same-cycle read and write returns pre-write contents
        access(1'b1, 1'b1, 5'd0, 32'h1234_5678, 4'hF);
        check_eq("rw_same_old", 64'(readData), 64'h0);
        check_eq("rw_same_port0", 64'(portOut[31:0]), 64'h1234_5678);
        rd(5'd0);
        check_eq("rw_same_new", 64'(readData), 64'h1234_5678);

        // Byte-masked writes
        wr(5'd1, 32'hDEAD_BEEF, 4'b0101);
        check_eq("bytemask_port1", 64'(portOut[63:32]), 64'h00AD_00EF);
        rd(5'd1);
        check_eq("bytemask_read", 64'(readData), 64'h00AD_00EF);
        wr(5'd1, 32'h1122_3344, 4'b1010);
        check_eq("bytemask_merge", 64'(portOut), 64'h11AD_33EF_1234_5678);

        // Unmapped and read-only words
        wr(5'd7, 32'hFFFF_FFFF, 4'hF);
        rd(5'd7);
        check_eq("unmapped_read", 64'(readData), 64'h0);
        wr(5'd2, 32'hFFFF_FFFF, 4'hF);
        rd(5'd2);
        check_eq("ro_input_write", 64'(readData), 64'h0);
        check_eq("ro_no_side_effect", 64'(portOut), 64'h11AD_33EF_1234_5678);
        rd(5'd0);
        tick();
        tick();
        check_eq("readdata_hold", 64'(readData), 64'h1234_5678);

        // Input change: synchroniser depth and flag latency
        portIn[31:0] = 32'h5;
        rd(5'd4);
        check_eq("flag_early", 64'(readData), 64'h0);
        rd(5'd2);
        check_eq("sync_early", 64'(readData), 64'h0);
        rd(5'd2);
        check_eq("sync_in", 64'(readData), 64'h5);
        rd(5'd4);
        check_eq("flag_set", 64'(readData), 64'h1);

        // Set beats clear in the same cycle, then clear semantics
        portIn[31:0] = 32'h6;
        tick();
        tick();
        wr(5'd4, 32'h1, 4'b0001);
        rd(5'd4);
        check_eq("set_over_clr", 64'(readData), 64'h1);
        wr(5'd4, 32'h1, 4'b1110);
        rd(5'd4);
        check_eq("clr_masked", 64'(readData), 64'h1);
        wr(5'd4, 32'h0, 4'b0001);
        rd(5'd4);
        check_eq("clr_zero", 64'(readData), 64'h1);
        wr(5'd4, 32'h1, 4'b0001);
        rd(5'd4);
        check_eq("clr_done", 64'(readData), 64'h0);

        // Interrupt mask word and irq behaviour
        wr(5'd5, 32'h2, 4'b0001);
        rd(5'd5);
        check_eq("mask_read", 64'(readData), IRQ_BUILD ? 64'h2 : 64'h0);
        portIn[63:32] = 32'h10;
        repeat (3) tick();
        check_eq("irq_early", 64'(irq), 64'h0);
        tick();
        check_eq("irq_set", 64'(irq), IRQ_BUILD ? 64'h1 : 64'h0);
        rd(5'd4);
        check_eq("flag_port1", 64'(readData), 64'h2);
        wr(5'd4, 32'h2, 4'b0001);
        check_eq("irq_hold", 64'(irq), IRQ_BUILD ? 64'h1 : 64'h0);
        tick();
        check_eq("irq_clr", 64'(irq), 64'h0);
        rd(5'd4);
        check_eq("flag_port1_clr", 64'(readData), 64'h0);

        // Asynchronous reset in the middle of a write
        rd(5'd0);
        check_eq("pre_rst_read", 64'(readData), 64'h1234_5678);
        portIn        = {32'h0000_0100, 32'h0};
        writeEnable   = 1'b1;
        readEnable    = 1'b1;
        address       = 5'd0;
        writeData     = 32'hCAFE_F00D;
        byteWriteMask = 4'hF;
        #2;
        not_reset = 1'b0;
        #1;
        check_eq("async_rst_out", 64'(portOut), 64'h0);
        check_eq("async_rst_rdata", 64'(readData), 64'h0);
        check_eq("async_rst_irq", 64'(irq), 64'h0);
        tick();
        writeEnable = 1'b0;
        readEnable  = 1'b0;
        tick();
        not_reset = 1'b1;
        check_eq("rst_write_aborted", 64'(portOut), 64'h0);

        // Input nonzero through reset shows up as a change after release
        rd(5'd4);
        check_eq("rst_flag_e1", 64'(readData), 64'h0);
        rd(5'd4);
        check_eq("rst_flag_e2", 64'(readData), 64'h0);
        tick();
        rd(5'd4);
        check_eq("rst_in_flag", 64'(readData), 64'h2);
        rd(5'd3);
        check_eq("rst_in_sync", 64'(readData), 64'h100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
